iterative_divider: RTL and testbench

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

---
 rtl/iterative_divider.sv | 183 ++++++++++++++++++
 tb/tb_iterative_divider.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle.
// Operands are reduced to magnitudes on capture, divided MSB-first, and the
// signs are restored in a single fix-up cycle before the results are loaded.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out,
  output logic             div_zero_out
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  STEPS   = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   quo_r;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   div_r;      // divisor magnitude
  logic [WIDTH:0]     rem_r;      // partial remainder
  logic [WIDTH-1:0]   a_cap_r;    // raw dividend, returned as remainder on divide-by-zero
  logic               b_zero_r;
  logic               qneg_r;
  logic               rneg_r;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH+1:0]   wide_s;
  logic [WIDTH:0]     diff_s;
  logic               ge_s;
  logic [WIDTH-1:0]   q_fix_s;
  logic [WIDTH-1:0]   r_fix_s;

  // A new request is only taken when no division is in flight.
  assign accept_s = start_in && ((state_r == IDLE) || (state_r == DONE));

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag_s = A_in;
    b_mag_s = B_in;
    if (signed_in && A_in[WIDTH-1]) begin
      a_mag_s = -A_in;
    end else begin
      a_mag_s = A_in;
    end
    if (signed_in && B_in[WIDTH-1]) begin
      b_mag_s = -B_in;
    end else begin
      b_mag_s = B_in;
    end
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    wide_s = {rem_r, quo_r[WIDTH-1]};
    ge_s   = (wide_s >= {2'b00, div_r});
    diff_s = wide_s[WIDTH:0] - {1'b0, div_r};
  end

  // Sign correction and divide-by-zero substitution for the final results.
  always_comb begin
    q_fix_s = quo_r;
    r_fix_s = rem_r[WIDTH-1:0];
    if (b_zero_r) begin
      q_fix_s = '1;
      r_fix_s = a_cap_r;
    end else begin
      q_fix_s = qneg_r ? -quo_r : quo_r;
      r_fix_s = rneg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; CALC leaves once all WIDTH steps are recorded.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_in) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == STEPS) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX: begin
        state_next_s = DONE;
      end
      DONE: begin
        if (start_in) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, then iterate the shift-subtract.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_r  <= '0;
      quo_r    <= '0;
      div_r    <= '0;
      rem_r    <= '0;
      a_cap_r  <= '0;
      b_zero_r <= 1'b0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
    end else if (accept_s) begin
      count_r  <= '0;
      quo_r    <= a_mag_s;
      div_r    <= b_mag_s;
      rem_r    <= '0;
      a_cap_r  <= A_in;
      b_zero_r <= (B_in == '0);
      qneg_r   <= signed_in & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
      rneg_r   <= signed_in & A_in[WIDTH-1];
    end else if ((state_r == CALC) && (count_r != STEPS)) begin
      count_r <= count_r + CNT_ONE;
      if (ge_s) begin
        rem_r <= diff_s;
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= wide_s[WIDTH:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Registered status and result outputs; results load when leaving FIX.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      Q_out        <= '0;
      R_out        <= '0;
      div_zero_out <= 1'b0;
    end else begin
      busy_out <= (state_next_s == CALC) || (state_next_s == FIX);
      done_out <= (state_next_s == DONE);
      if (state_r == FIX) begin
        Q_out        <= q_fix_s;
        R_out        <= r_fix_s;
        div_zero_out <= b_zero_r;
      end
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider at WIDTH 32, with a
// scoreboard of expected results and completion cycles.
module tb_iterative_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_in = 1'b0;
  logic         start_in = 1'b0;
  logic         signed_in = 1'b0;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] Q_out;
  logic [W-1:0] R_out;
  logic         div_zero_out;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e_m;

  iterative_divider #(.WIDTH(W)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .signed_in    (signed_in),
    .A_in         (A_in),
    .B_in         (B_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .Q_out        (Q_out),
    .R_out        (R_out),
    .div_zero_out (div_zero_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    exp_t e;
    e.cyc = 0;
    e.dz  = 1'b0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'h0000_0000;
    end else if (sg) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done_out === 1'b1) begin
      if (sb.size() != 0) begin
        e_m = sb.pop_front();
        check("q", Q_out, e_m.q);
        check("r", R_out, e_m.r);
        check("div_zero", div_zero_out, e_m.dz);
        check("done_cycle", cyc, e_m.cyc);
      end else begin
        check("spurious_done", done_out, 1'b0);
      end
    end
  end

  // Drive a one-cycle start from the low clock phase and queue the expectation.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    A_in = a;
    B_in = b;
    signed_in = sg;
    start_in = 1'b1;
    e.q = q;
    e.r = r;
    e.dz = dz;
    e.cyc = cyc + 1 + W + 2;
    sb.push_back(e);
    @(negedge clk);
    #1;
    start_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * W + 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    start_op(a, b, sg, q, r, dz);
    check("busy_after_start", busy_out, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   ndone;
    exp_t m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #1 rst_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_q", Q_out, 32'h0);
    check("rst_r", R_out, 32'h0);
    check("rst_dz", div_zero_out, 1'b0);

    // Release reset and request in the same low phase: first edge accepts.
    rst_in = 1'b0;
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0);

    run_op(32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op(32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'h0, 1'b0);

    // Overflow case, with an ignored start and operand changes mid-CALC.
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    A_in = 32'd5;
    B_in = 32'd3;
    signed_in = 1'b0;
    start_in = 1'b1;
    @(negedge clk);
    #1;
    start_in = 1'b0;
    check("busy_ignored_start", busy_out, 1'b1);
    A_in = 32'd77;
    B_in = 32'd11;
    drain();

    // Back-to-back: start held high through DONE.
    A_in = 32'd50;
    B_in = 32'd5;
    signed_in = 1'b0;
    start_in = 1'b1;
    t0 = cyc + 1;
    sb.push_back('{q: 32'd10, r: 32'd0, dz: 1'b0, cyc: t0 + W + 2});
    sb.push_back('{q: 32'd9, r: 32'd0, dz: 1'b0, cyc: t0 + W + 3 + W + 2});
    @(negedge clk);
    #1;
    A_in = 32'd81;
    B_in = 32'd9;
    while (cyc < t0 + W + 1) begin
      @(negedge clk);
      #1;
    end
    check("b2b_busy_before", busy_out, 1'b1);
    @(negedge clk);
    #1;
    check("b2b_busy_low", busy_out, 1'b0);
    check("b2b_done", done_out, 1'b1);
    @(negedge clk);
    #1;
    check("b2b_busy_again", busy_out, 1'b1);
    check("b2b_done_gone", done_out, 1'b0);
    start_in = 1'b0;
    drain();

    // Reset in the middle of CALC abandons the operation.
    start_op(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0);
    repeat (8) @(negedge clk);
    #2;
    rst_in = 1'b1;
    #1;
    check("midrst_busy", busy_out, 1'b0);
    check("midrst_done", done_out, 1'b0);
    check("midrst_q", Q_out, 32'h0);
    check("midrst_r", R_out, 32'h0);
    check("midrst_dz", div_zero_out, 1'b0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_in = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      #1;
      if (done_out === 1'b1) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    run_op(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0);

    // Random operands against the bench model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? $urandom : $urandom_range(1, 500);
      if (i == 6) rb = -rb;
      m = model(ra, rb, i[0]);
      run_op(ra, rb, i[0], m.q, m.r, m.dz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
